// File: rtl/muldiv_unit.sv
// muldiv_unit: EX-stage multiply/divide unit that owns the HI/LO registers.
// MULT/MULTU/DIV/DIVU/MTHI/MTLO are accepted only while IDLE. Multi-cycle
// operations run in the background, and mdstallE is high while the unit is busy.
//
// Parameters:
//   WIDTH       operand and HI/LO width; a divide iterates WIDTH cycles
//   MUL_CYCLES  multiply latency (>=1); 1 writes the product at the accept edge
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-high; aborts any running op
//   muldivopE    3-bit op code from E
//   srcaE        rs operand (dividend / multiplicand / MTHI,MTLO data)
//   srcbE        rt operand (divisor / multiplier)
//   hi, lo       HI/LO registers (registered outputs)
//   mdstallE     busy flag, a decode of the state register only
//   mdstall_cnt  count of stalled cycles (present only with MULDIV_PERF_CNT_EN)
//
// Optional feature: define MULDIV_PERF_CNT_EN to add the 32-bit stall counter.
module muldiv_unit #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       muldivopE,
    input  logic [WIDTH-1:0] srcaE,
    input  logic [WIDTH-1:0] srcbE,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             mdstallE
`ifdef MULDIV_PERF_CNT_EN
    ,
    output logic [31:0]      mdstall_cnt
`endif
);

    localparam int CW  = $clog2(WIDTH) + 1;
    localparam int MCW = $clog2(MUL_CYCLES) + 1;

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6,
        OP_NONE7 = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIX  = 2'd3
    } state_e;

    state_e           r_state;
    logic [WIDTH-1:0] r_hi, r_lo;
    logic [WIDTH-1:0] r_ma, r_mb;
    logic             r_msigned;
    logic [MCW-1:0]   r_mcnt;
    logic [WIDTH-1:0] r_rem, r_quo, r_dvsr;
    logic             r_qneg, r_rneg;
    logic [CW-1:0]    r_cnt;

    op_e w_op;
    assign w_op = op_e'(muldivopE);

    // A single multiplier is shared by the IDLE accept path and the MUL drain path.
    logic [WIDTH-1:0]   w_ma, w_mb;
    logic               w_msgn;
    logic [2*WIDTH-1:0] w_ext_a, w_ext_b, w_prod;

    always_comb begin
        w_ma   = srcaE;
        w_mb   = srcbE;
        w_msgn = (w_op == OP_MULT);
        if (r_state == S_MUL) begin
            w_ma   = r_ma;
            w_mb   = r_mb;
            w_msgn = r_msigned;
        end
    end

    assign w_ext_a = {{WIDTH{w_msgn & w_ma[WIDTH-1]}}, w_ma};
    assign w_ext_b = {{WIDTH{w_msgn & w_mb[WIDTH-1]}}, w_mb};
    assign w_prod  = w_ext_a * w_ext_b;

    // Operand magnitudes for the divider. MIN_INT maps to itself, which reads
    // correctly as an unsigned magnitude.
    logic             w_asgn, w_bsgn;
    logic [WIDTH-1:0] w_abs_a, w_abs_b;

    assign w_asgn  = (w_op == OP_DIV) & srcaE[WIDTH-1];
    assign w_bsgn  = (w_op == OP_DIV) & srcbE[WIDTH-1];
    assign w_abs_a = w_asgn ? -srcaE : srcaE;
    assign w_abs_b = w_bsgn ? -srcbE : srcbE;

    // One restoring step: shift the next dividend bit into the partial
    // remainder, then keep the difference if it did not go negative.
    logic [WIDTH:0] w_shift, w_diff;

    assign w_shift = {r_rem, r_quo[WIDTH-1]};
    assign w_diff  = w_shift - {1'b0, r_dvsr};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_hi      <= '0;
            r_lo      <= '0;
            r_ma      <= '0;
            r_mb      <= '0;
            r_msigned <= 1'b0;
            r_mcnt    <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_dvsr    <= '0;
            r_qneg    <= 1'b0;
            r_rneg    <= 1'b0;
            r_cnt     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    case (w_op)
                        OP_MTHI: r_hi <= srcaE;
                        OP_MTLO: r_lo <= srcaE;
                        OP_MULT, OP_MULTU: begin
                            if (MUL_CYCLES == 1) begin
                                {r_hi, r_lo} <= w_prod;
                            end else begin
                                r_ma      <= srcaE;
                                r_mb      <= srcbE;
                                r_msigned <= (w_op == OP_MULT);
                                r_mcnt    <= MCW'(MUL_CYCLES - 2);
                                r_state   <= S_MUL;
                            end
                        end
                        OP_DIV, OP_DIVU: begin
                            if (srcbE == '0) begin
                                r_lo <= '1;
                                r_hi <= srcaE;
                            end else begin
                                r_rem   <= '0;
                                r_quo   <= w_abs_a;
                                r_dvsr  <= w_abs_b;
                                r_qneg  <= w_asgn ^ w_bsgn;
                                r_rneg  <= w_asgn;
                                r_cnt   <= CW'(WIDTH - 1);
                                r_state <= S_DIV;
                            end
                        end
                        default: ;
                    endcase
                end
                S_MUL: begin
                    if (r_mcnt == '0) begin
                        {r_hi, r_lo} <= w_prod;
                        r_state      <= S_IDLE;
                    end else begin
                        r_mcnt <= r_mcnt - 1'b1;
                    end
                end
                S_DIV: begin
                    if (!w_diff[WIDTH]) begin
                        r_rem <= w_diff[WIDTH-1:0];
                        r_quo <= {r_quo[WIDTH-2:0], 1'b1};
                    end else begin
                        r_rem <= w_shift[WIDTH-1:0];
                        r_quo <= {r_quo[WIDTH-2:0], 1'b0};
                    end
                    if (r_cnt == '0) begin
                        r_state <= S_FIX;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_FIX: begin
                    r_lo    <= r_qneg ? -r_quo : r_quo;
                    r_hi    <= r_rneg ? -r_rem : r_rem;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign hi       = r_hi;
    assign lo       = r_lo;
    assign mdstallE = (r_state != S_IDLE);

`ifdef MULDIV_PERF_CNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (mdstallE) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign mdstall_cnt = r_stall_cnt;
`else
    // Stall counter is not built.
`endif

endmodule
